match_count_datapath: RTL and testbench
=======================================

MATCH_COUNT_DATAPATH -- requirements
Module: match_count_datapath

Interface
REQ-001 The block SHALL have parameter CNT_W, default 8, meaning the width of the match counter.
REQ-002 The block SHALL have parameter THRESH, default 4, meaning the match count that asserts status (legal range 1..2^CNT_W-1).
REQ-003 The block SHALL have parameter HOLD_CYC, default 3, meaning the number of cycles status is held high (legal range >=1).
REQ-004 Port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 Port rst, input, 1 bit: asynchronous, active-high reset.
REQ-006 Port det_in, input, 1 bit: match indication from the upstream Mealy controller (q_out); sampled each rising clk edge.
REQ-007 Port clr, input, 1 bit: synchronous clear request from the controller.
REQ-008 Port en, input, 1 bit: count enable; det_in is ignored while en=0.
REQ-009 Port status, output, 1 bit: threshold-reached flag fed back to the controller.
REQ-010 Port count, output, CNT_W bits: current match count.
REQ-011 Port sat, output, 1 bit: sticky flag set when an increment is attempted at the all-ones count.
REQ-012 Port busy, output, 1 bit: high whenever the state is not IDLE.

Function
REQ-013 The block SHALL implement a three-state FSM: IDLE, COUNT, HOLD; all outputs are registered, with no combinational path from input to output.
REQ-014 A "hit" SHALL be a cycle where det_in=1 and en=1 at the clk edge; each hit cycle counts once, including consecutive high cycles.
REQ-015 In IDLE with count=0, a hit SHALL set count=1 and move to COUNT; if THRESH=1 it SHALL instead move directly to HOLD with status=1.
REQ-016 In COUNT, a hit SHALL increment count by 1; if the new count equals THRESH, then on the same edge status SHALL go to 1 and the state SHALL go to HOLD.
REQ-017 status SHALL therefore be high in the cycle after the THRESH-th hit (latency 1 clk).
REQ-018 In HOLD, status SHALL stay 1 for exactly HOLD_CYC cycles, counted by an internal hold timer loaded at HOLD entry.
REQ-019 In HOLD, hits SHALL continue to increment count.
REQ-020 At the all-ones count, a further hit SHALL leave count unchanged and set sat=1; sat stays 1 until clr or rst.
REQ-021 When the hold timer expires, the FSM SHALL go to IDLE with count=0 and status=0 on the same edge; a hit on that same edge is dropped.
REQ-022 clr=1 SHALL, from any state, force IDLE, count=0, status=0, sat=0 and timer=0 on the next edge.
REQ-023 clr SHALL take priority over hit, threshold detection and timer expiry occurring in the same cycle.
REQ-024 With en=0, count, state and timer progress SHALL follow the same rules with hits suppressed; the HOLD timer SHALL still run.
REQ-025 The count width SHALL be exactly CNT_W bits with no wrap-around; comparison against THRESH SHALL be an unsigned equality on the post-increment value.

Reset
REQ-026 Assertion of rst SHALL immediately (asynchronously) force IDLE, count=0, status=0, sat=0, busy=0 and hold timer=0.
REQ-027 After rst deasserts, the first hit SHALL be recognised at the first rising clk edge where rst=0.
REQ-028 rst asserted mid-HOLD SHALL drop status within the same cycle, without waiting for a clk edge.

Verification (THRESH=4, HOLD_CYC=3, CNT_W=8)
REQ-029 Bench: rst pulse, then det_in=1 for 4 consecutive cycles with en=1 -> count steps 1,2,3,4; status=1 in cycles 5-7; count=0, status=0, busy=0 in cycle 8.
REQ-030 Bench: hits on alternate cycles with clr=1 coinciding with the 3rd hit -> count=0, status never asserted, state IDLE.
REQ-031 Bench: det_in=1 held with en=0 for 10 cycles -> count stays 0, busy=0; then en=1 for 4 cycles -> status=1 after the 4th.
REQ-032 Bench: parameter THRESH=255, 260 consecutive hits -> count=255, status=1 at 255, sat=1 after the 256th hit; clr -> sat=0.
REQ-033 Bench: rst asserted between clk edges during HOLD -> status, count and busy go to 0 before the next edge.
REQ-034 Bench: a hit on the timer-expiry edge -> count=0 and IDLE afterwards; the next hit gives count=1.

Source files
------------

// File: rtl/match_count_datapath.sv
// Counts det_in&en hits; raises status for HOLD_CYC cycles once THRESH hits are seen; sticky sat on overflow attempt.
// Latency: 1 clk from hit to registered outputs; no backpressure, en simply gates hits.
module match_count_datapath #(
   parameter int CNT_W    = 8,
   parameter int THRESH   = 4,
   parameter int HOLD_CYC = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             det_in,
   input  logic             clr,
   input  logic             en,
   output logic             status,
   output logic [CNT_W-1:0] count,
   output logic             sat,
   output logic             busy
);

   localparam int TMR_W = (HOLD_CYC < 1) ? 1 : $clog2(HOLD_CYC + 1);
   localparam logic [CNT_W-1:0] THRESH_V = CNT_W'(THRESH);
   localparam logic [TMR_W-1:0] HOLD_V   = TMR_W'(HOLD_CYC);
   localparam logic [CNT_W-1:0] CNT_MAX  = '1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      COUNT = 2'd1,
      HOLD  = 2'd2
   } state_t;

   state_t           state;
   logic [TMR_W-1:0] timer;

   logic             hit;
   logic             at_max;
   logic [CNT_W-1:0] cnt_inc;
   logic             thresh_hit;
   logic             tmr_expire;

   assign hit        = det_in & en;
   assign at_max     = (count == CNT_MAX);
   // Count never wraps: at all-ones the "incremented" value is the count itself.
   assign cnt_inc    = at_max ? count : count + 1'b1;
   assign thresh_hit = hit && !at_max && (cnt_inc == THRESH_V);
   assign tmr_expire = (timer <= TMR_W'(1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= IDLE;
         count  <= '0;
         status <= 1'b0;
         sat    <= 1'b0;
         busy   <= 1'b0;
         timer  <= '0;
      end else if (clr) begin
         state  <= IDLE;
         count  <= '0;
         status <= 1'b0;
         sat    <= 1'b0;
         busy   <= 1'b0;
         timer  <= '0;
      end else begin
         case (state)
            IDLE, COUNT: begin
               if (hit) begin
                  count <= cnt_inc;
                  busy  <= 1'b1;
                  if (at_max) sat <= 1'b1;
                  if (thresh_hit) begin
                     state  <= HOLD;
                     status <= 1'b1;
                     timer  <= HOLD_V;
                  end else begin
                     state  <= COUNT;
                  end
               end
            end
            HOLD: begin
               // Expiry wins over a coincident hit, which is dropped.
               if (tmr_expire) begin
                  state  <= IDLE;
                  count  <= '0;
                  status <= 1'b0;
                  busy   <= 1'b0;
                  timer  <= '0;
               end else begin
                  timer <= timer - 1'b1;
                  if (hit) begin
                     count <= cnt_inc;
                     if (at_max) sat <= 1'b1;
                  end
               end
            end
            default: begin
               state  <= IDLE;
               count  <= '0;
               status <= 1'b0;
               busy   <= 1'b0;
               timer  <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_match_count_datapath.sv
// Scoreboard bench for match_count_datapath: stimulus queues hand-computed expectations,
// monitors compare after each clk edge and right after asynchronous reset assertion.
module tb_match_count_datapath;

   logic       clk = 1'b0;
   logic       rst;
   logic       det_in;
   logic       en;
   logic       clr;

   logic       st_a, sat_a, busy_a;
   logic [7:0] cnt_a;
   logic       st_b, sat_b, busy_b;
   logic [7:0] cnt_b;

   match_count_datapath #(.CNT_W(8), .THRESH(4), .HOLD_CYC(3)) u_dut_a (
      .clk(clk), .rst(rst), .det_in(det_in), .clr(clr), .en(en),
      .status(st_a), .count(cnt_a), .sat(sat_a), .busy(busy_a)
   );

   match_count_datapath #(.CNT_W(8), .THRESH(255), .HOLD_CYC(8)) u_dut_b (
      .clk(clk), .rst(rst), .det_in(det_in), .clr(clr), .en(en),
      .status(st_b), .count(cnt_b), .sat(sat_b), .busy(busy_b)
   );

   always #5 clk = ~clk;

   typedef struct {
      int dut;
      int id;
      int cnt;
      int st;
      int sat;
      int busy;
   } exp_t;

   exp_t sb_q[$];
   exp_t async_q[$];
   event probe_ev;
   int   n_total = 0;
   int   n_bad   = 0;
   int   step_id = 0;

   task automatic cmp(input string where, input string what, input int id,
                      input logic [31:0] act, input int exp);
      n_total++;
      if (act !== 32'(exp)) begin
         n_bad++;
         $display("FAIL %s step %0d %s: got %0d want %0d", where, id, what, act, exp);
      end
   endtask

   task automatic check_entry(input exp_t e, input string where);
      logic [31:0] c;
      logic        s, sa, b;
      if (e.dut == 0) begin
         c = 32'(cnt_a); s = st_a; sa = sat_a; b = busy_a;
      end else begin
         c = 32'(cnt_b); s = st_b; sa = sat_b; b = busy_b;
      end
      cmp(where, "count",  e.id, c,        e.cnt);
      cmp(where, "status", e.id, 32'(s),   e.st);
      cmp(where, "sat",    e.id, 32'(sa),  e.sat);
      cmp(where, "busy",   e.id, 32'(b),   e.busy);
   endtask

   // Clocked monitor: one expectation per edge, sampled 1 time unit after it.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check_entry(e, "clk");
         end
      end
   end

   // Asynchronous monitor: fires between edges when reset is asserted.
   initial begin
      exp_t e;
      forever begin
         @(probe_ev);
         while (async_q.size() > 0) begin
            e = async_q.pop_front();
            check_entry(e, "async");
         end
      end
   end

   task automatic step(input logic d, input logic e, input logic c,
                       input int ec, input int es, input int esat, input int eb, input int dut);
      @(negedge clk);
      det_in = d;
      en     = e;
      clr    = c;
      step_id++;
      sb_q.push_back('{dut, step_id, ec, es, esat, eb});
   endtask

   task automatic async_zero_check();
      step_id++;
      async_q.push_back('{0, step_id, 0, 0, 0, 0});
      async_q.push_back('{1, step_id, 0, 0, 0, 0});
      ->probe_ev;
   endtask

   task automatic do_rst();
      @(negedge clk);
      det_in = 1'b0; en = 1'b0; clr = 1'b0;
      rst = 1'b1;
      #1;
      async_zero_check();
      @(negedge clk);
      rst = 1'b0;
   endtask

   // Assert reset shortly after the edge that just completed, well before the next one.
   task automatic mid_rst();
      @(posedge clk);
      #2;
      det_in = 1'b0;
      rst    = 1'b1;
      #1;
      async_zero_check();
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      #100000;
      n_bad++;
      $display("FAIL watchdog: got timeout want finish");
      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst = 1'b1; det_in = 1'b0; en = 1'b0; clr = 1'b0;
      do_rst();

      // Four consecutive hits, status for three cycles, then back to idle.
      step(1, 1, 0, 1, 0, 0, 1, 0);
      step(1, 1, 0, 2, 0, 0, 1, 0);
      step(1, 1, 0, 3, 0, 0, 1, 0);
      step(1, 1, 0, 4, 1, 0, 1, 0);
      step(0, 1, 0, 4, 1, 0, 1, 0);
      step(0, 1, 0, 4, 1, 0, 1, 0);
      step(0, 1, 0, 0, 0, 0, 0, 0);

      // Alternate hits, clr on the third hit.
      step(1, 1, 0, 1, 0, 0, 1, 0);
      step(0, 1, 0, 1, 0, 0, 1, 0);
      step(1, 1, 0, 2, 0, 0, 1, 0);
      step(0, 1, 0, 2, 0, 0, 1, 0);
      step(1, 1, 1, 0, 0, 0, 0, 0);
      step(0, 1, 0, 0, 0, 0, 0, 0);

      // clr beats the threshold-reaching hit.
      step(1, 1, 0, 1, 0, 0, 1, 0);
      step(1, 1, 0, 2, 0, 0, 1, 0);
      step(1, 1, 0, 3, 0, 0, 1, 0);
      step(1, 1, 1, 0, 0, 0, 0, 0);

      // det_in high with en low is ignored; HOLD timer still runs with en low.
      for (int i = 0; i < 10; i++) step(1, 0, 0, 0, 0, 0, 0, 0);
      step(1, 1, 0, 1, 0, 0, 1, 0);
      step(1, 1, 0, 2, 0, 0, 1, 0);
      step(1, 1, 0, 3, 0, 0, 1, 0);
      step(1, 1, 0, 4, 1, 0, 1, 0);
      step(1, 0, 0, 4, 1, 0, 1, 0);
      step(1, 0, 0, 4, 1, 0, 1, 0);
      step(1, 0, 0, 0, 0, 0, 0, 0);

      // Hits keep counting in HOLD; the hit on the expiry edge is dropped.
      step(1, 1, 0, 1, 0, 0, 1, 0);
      step(1, 1, 0, 2, 0, 0, 1, 0);
      step(1, 1, 0, 3, 0, 0, 1, 0);
      step(1, 1, 0, 4, 1, 0, 1, 0);
      step(1, 1, 0, 5, 1, 0, 1, 0);
      step(1, 1, 0, 6, 1, 0, 1, 0);
      step(1, 1, 0, 0, 0, 0, 0, 0);
      step(1, 1, 0, 1, 0, 0, 1, 0);
      step(1, 1, 0, 2, 0, 0, 1, 0);
      step(1, 1, 0, 3, 0, 0, 1, 0);
      step(1, 1, 0, 4, 1, 0, 1, 0);
      step(0, 1, 1, 0, 0, 0, 0, 0);

      // Asynchronous reset in the middle of HOLD, then a hit right after release.
      step(1, 1, 0, 1, 0, 0, 1, 0);
      step(1, 1, 0, 2, 0, 0, 1, 0);
      step(1, 1, 0, 3, 0, 0, 1, 0);
      step(1, 1, 0, 4, 1, 0, 1, 0);
      mid_rst();
      step(1, 1, 0, 1, 0, 0, 1, 1);
      step(0, 1, 0, 1, 0, 0, 1, 0);
      step(0, 1, 1, 0, 0, 0, 0, 0);

      // THRESH=255 instance: saturation at all-ones and sticky sat, cleared by clr.
      do_rst();
      for (int i = 1; i <= 260; i++)
         step(1, 1, 0, (i > 255) ? 255 : i, (i >= 255) ? 1 : 0, (i >= 256) ? 1 : 0, 1, 1);
      step(0, 1, 1, 0, 0, 0, 0, 1);
      step(0, 1, 0, 0, 0, 0, 0, 1);

      @(negedge clk);
      @(negedge clk);
      n_total++;
      if (sb_q.size() != 0 || async_q.size() != 0) begin
         n_bad++;
         $display("FAIL drain: got %0d pending want 0", sb_q.size() + async_q.size());
      end
      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
